// File: rtl/pio_bidir_irq_pkg.sv
// Shared register map and edge-capture encodings for the bidirectional PIO.
package pio_pkg;
   localparam logic [2:0] PIO_DATA     = 3'd0;
   localparam logic [2:0] PIO_DIR      = 3'd1;
   localparam logic [2:0] PIO_IRQ_MASK = 3'd2;
   localparam logic [2:0] PIO_EDGE_CAP = 3'd3;
   localparam logic [2:0] PIO_OUTSET   = 3'd4;
   localparam logic [2:0] PIO_OUTCLR   = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/pio_bidir_irq_if.sv
// Avalon-MM slave register bus for the PIO block.
interface pio_bidir_irq_if #(parameter int WIDTH = 8);
   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_bidir_irq_sync_edge.sv
// Per-bit input synchroniser, previous-sample register and edge detector.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   input  logic             arm,
   output logic [WIDTH-1:0] edge_vec,
   output logic [WIDTH-1:0] sync_val
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] raw;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain <= '0;
         prev  <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], in_port};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign sync_val = chain[SYNC_STAGES-1];

   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: raw = ~sync_val & prev;
         EDGE_ANY:     raw = sync_val ^ prev;
         default:      raw = sync_val & ~prev;
      endcase
   end

   // Arming masks the transient while the chain fills with the post-reset pin state.
   assign edge_vec = raw & {WIDTH{arm}};
endmodule

// File: rtl/pio_bidir_irq.sv
// Avalon-MM GPIO slave: per-bit drive/tri-state, synchronised input, edge capture, level irq.
module pio_bidir_irq
   import pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               EDGE_TYPE   = EDGE_RISING,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   pio_bidir_irq_if.slave   bus,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe_port,
   output logic             irq
);
   localparam int              AW       = $clog2(SYNC_STAGES + 2);
   localparam logic [AW-1:0]   ARM_DONE = AW'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] data_q, dir_q, mask_q, cap_q;
   logic [WIDTH-1:0] edge_vec, sync_val, cap_clr;
   logic [AW-1:0]    arm_cnt;
   logic             arm, wr;

   assign wr      = bus.chipselect & ~bus.write_n;
   assign arm     = (arm_cnt == ARM_DONE);
   assign cap_clr = (wr && bus.address == PIO_EDGE_CAP) ? bus.writedata : '0;

   pio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_port  (in_port),
      .arm      (arm),
      .edge_vec (edge_vec),
      .sync_val (sync_val)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q  <= OUT_RESET;
         dir_q   <= DIR_RESET;
         mask_q  <= '0;
         cap_q   <= '0;
         arm_cnt <= '0;
      end else begin
         if (!arm) arm_cnt <= arm_cnt + 1'b1;
         // A new edge on a bit being cleared in the same cycle must survive.
         cap_q <= (cap_q & ~cap_clr) | edge_vec;
         if (wr) begin
            case (bus.address)
               PIO_DATA:     data_q <= bus.writedata;
               PIO_DIR:      dir_q  <= bus.writedata;
               PIO_IRQ_MASK: mask_q <= bus.writedata;
               PIO_OUTSET:   data_q <= data_q | bus.writedata;
               PIO_OUTCLR:   data_q <= data_q & ~bus.writedata;
               default:      ;
            endcase
         end
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         PIO_DATA:     bus.readdata = sync_val;
         PIO_DIR:      bus.readdata = dir_q;
         PIO_IRQ_MASK: bus.readdata = mask_q;
         PIO_EDGE_CAP: bus.readdata = cap_q;
         default:      bus.readdata = '0;
      endcase
   end

   assign out_port = data_q;
   assign oe_port  = dir_q;
   assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: a rising-edge instance with non-zero reset values and an any-edge instance.
module tb_pio_bidir_irq;
   import pio_pkg::*;
   localparam int S = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [7:0] in_a, out_a, oe_a, in_b, out_b, oe_b;
   logic       irq_a, irq_b;

   pio_bidir_irq_if #(.WIDTH(8)) bus_a ();
   pio_bidir_irq_if #(.WIDTH(8)) bus_b ();

   pio_bidir_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_RISING),
                   .OUT_RESET(8'hA5), .DIR_RESET(8'h0F)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .in_port(in_a),
      .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

   pio_bidir_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_ANY),
                   .OUT_RESET(8'h00), .DIR_RESET(8'h00)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .in_port(in_b),
      .out_port(out_b), .oe_port(oe_b), .irq(irq_b));

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] sb[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
      bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
      bus_a.address = a; bus_a.writedata = d;
      step();
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
   endtask

   task automatic rd_a(input logic [2:0] a, output logic [7:0] d);
      bus_a.address = a;
      #1;
      d = bus_a.readdata;
   endtask

   task automatic test_reset();
      logic [7:0] r;
      reset_n = 1'b0;
      in_a = 8'hFF; in_b = 8'h00;
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = '0; bus_a.writedata = '0;
      bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = '0; bus_b.writedata = '0;
      repeat (3) step();
      n_chk++; if (out_a !== 8'hA5) begin n_fail++; $display("FAIL reset_out: got %h want a5", out_a); end
      n_chk++; if (oe_a !== 8'h0F) begin n_fail++; $display("FAIL reset_oe: got %h want 0f", oe_a); end
      n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_a); end
      n_chk++; if ({out_b, oe_b, irq_b} !== 17'h0) begin n_fail++; $display("FAIL reset_b: got %h %h %b want 0", out_b, oe_b, irq_b); end
      rd_a(PIO_IRQ_MASK, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", r); end
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL reset_cap: got %h want 00", r); end
      reset_n = 1'b1;
   endtask

   task automatic test_no_false_edge();
      logic [7:0] r;
      repeat (S + 4) step();
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL arm_cap: got %h want 00", r); end
      rd_a(PIO_DATA, r);
      n_chk++; if (r !== 8'hFF) begin n_fail++; $display("FAIL arm_data: got %h want ff", r); end
   endtask

   task automatic test_outputs();
      logic [7:0] r, e;
      logic [2:0] addrs [3] = '{PIO_DATA, PIO_OUTSET, PIO_OUTCLR};
      logic [7:0] wds   [3] = '{8'h3C, 8'h01, 8'h0C};
      logic [7:0] exps  [3] = '{8'h3C, 8'h3D, 8'h31};
      for (int i = 0; i < 3; i++) begin
         sb.push_back(exps[i]);
         wr_a(addrs[i], wds[i]);
         e = sb.pop_front();
         n_chk++; if (out_a !== e) begin n_fail++; $display("FAIL out_seq%0d: got %h want %h", i, out_a, e); end
      end
      n_chk++; if (oe_a !== 8'h0F) begin n_fail++; $display("FAIL out_oe_kept: got %h want 0f", oe_a); end
      rd_a(PIO_OUTSET, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL rd_outset: got %h want 00", r); end
      rd_a(3'd6, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL rd_off6: got %h want 00", r); end
   endtask

   task automatic test_edge_capture();
      logic [7:0] r;
      in_a[2] = 1'b0;
      repeat (S + 3) step();
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL fall_ignored: got %h want 00", r); end
      in_a[2] = 1'b1;
      repeat (S) step();
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL rise_early: got %h want 00", r); end
      step();
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h04) begin n_fail++; $display("FAIL rise_cap: got %h want 04", r); end
      n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_unmasked: got %b want 0", irq_a); end
   endtask

   task automatic test_irq();
      logic [7:0] r;
      wr_a(PIO_IRQ_MASK, 8'h04);
      n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq_a); end
      wr_a(PIO_EDGE_CAP, 8'h04);
      n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b want 0", irq_a); end
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL cap_clr: got %h want 00", r); end
      in_a[2] = 1'b0;
      repeat (S + 2) step();
      in_a[2] = 1'b1;
      repeat (S) step();
      n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_pre_race: got %b want 0", irq_a); end
      // This clear is sampled on the same edge that sets the bit.
      wr_a(PIO_EDGE_CAP, 8'h04);
      rd_a(PIO_EDGE_CAP, r);
      n_chk++; if (r !== 8'h04) begin n_fail++; $display("FAIL set_wins: got %h want 04", r); end
      n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_race: got %b want 1", irq_a); end
      step();
      n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b want 1", irq_a); end
   endtask

   task automatic test_any_edge();
      logic [7:0] hist[$];
      logic [7:0] e;
      for (int c = 0; c < 32; c++) begin
         if (hist.size() == S) begin
            e = hist.pop_front();
            bus_b.address = PIO_DATA;
            #1;
            n_chk++; if (bus_b.readdata !== e) begin n_fail++; $display("FAIL any_data c%0d: got %h want %h", c, bus_b.readdata, e); end
         end
         if (c % 4 == 0) in_b[7] = ~in_b[7];
         hist.push_back(in_b);
         if (c % 4 == 3) begin
            bus_b.address = PIO_EDGE_CAP;
            #1;
            n_chk++; if (bus_b.readdata !== 8'h80) begin n_fail++; $display("FAIL any_cap c%0d: got %h want 80", c, bus_b.readdata); end
            bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; bus_b.writedata = 8'h80;
         end else if (c % 4 == 1) begin
            bus_b.address = PIO_EDGE_CAP;
            #1;
            n_chk++; if (bus_b.readdata !== 8'h00) begin n_fail++; $display("FAIL any_idle c%0d: got %h want 00", c, bus_b.readdata); end
         end
         step();
         bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
      end
   endtask

   task automatic test_reset_midwrite();
      logic [7:0] r;
      bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
      bus_a.address = PIO_DIR; bus_a.writedata = 8'hF0;
      reset_n = 1'b0;
      step();
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
      n_chk++; if (oe_a !== 8'h0F) begin n_fail++; $display("FAIL midrst_oe: got %h want 0f", oe_a); end
      n_chk++; if (out_a !== 8'hA5) begin n_fail++; $display("FAIL midrst_out: got %h want a5", out_a); end
      n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq_a); end
      rd_a(PIO_IRQ_MASK, r);
      n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL midrst_mask: got %h want 00", r); end
      reset_n = 1'b1;
      wr_a(PIO_DIR, 8'h55);
      n_chk++; if (oe_a !== 8'h55) begin n_fail++; $display("FAIL dir_after: got %h want 55", oe_a); end
   endtask

   initial begin
      test_reset();
      test_no_false_edge();
      test_outputs();
      test_edge_capture();
      test_irq();
      test_any_edge();
      test_reset_midwrite();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
